// File: rtl/adc_serial_write.sv
// Parallel-to-serial transmitter for the 12-bit ADC link: one-entry hold buffer, MSB-first shifter, frame/done strobes.
// Optional feature: define ADC_SERIAL_WRITE_PARITY_EN to append an even-parity bit after each word.
module adc_serial_write #(
    parameter int WIDTH = 12,
    parameter int GAP   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             out,
    output logic             frame,
    output logic             done
);

    localparam int CW       = $clog2(WIDTH + 1);
    localparam int GW       = (GAP > 1) ? $clog2(GAP) : 1;
    localparam int GAP_LAST = (GAP > 0) ? GAP - 1 : 0;
`ifdef ADC_SERIAL_WRITE_PARITY_EN
    localparam int LAST     = WIDTH;
`else
    localparam int LAST     = WIDTH - 1;
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        GAP_ST = 2'd2
    } state_t;

`ifdef ADC_SERIAL_WRITE_PARITY_EN
    // Parity bit that makes data plus parity carry an even number of ones.
    function automatic logic even_parity(input logic [WIDTH-1:0] w);
        return ^w;
    endfunction
    logic             par_r;
`endif

    state_t           state_r;
    logic [WIDTH-1:0] shift_r;
    logic [CW-1:0]    cnt_r;
    logic [GW-1:0]    gap_cnt_r;
    logic [WIDTH-1:0] hold_r;
    logic             hold_full_r;
    logic             out_r;
    logic             frame_r;
    logic             done_r;

    logic             accept_s;
    logic             to_hold_s;
    logic             load_s;
    logic             from_hold_s;
    logic             finish_s;
    logic [WIDTH-1:0] load_word_s;

    assign din_ready = !hold_full_r;
    assign out       = out_r;
    assign frame     = frame_r;
    assign done      = done_r;

    // A word only bypasses the hold buffer when the shifter is idle.
    assign accept_s  = din_valid && !hold_full_r;
    assign to_hold_s = accept_s && (state_r != IDLE);

    // Decide whether the shifter loads this edge, and from where.
    always_comb begin
        load_s      = 1'b0;
        from_hold_s = 1'b0;
        finish_s    = 1'b0;
        load_word_s = hold_r;
        case (state_r)
            IDLE: begin
                if (hold_full_r) begin
                    load_s      = 1'b1;
                    from_hold_s = 1'b1;
                end else if (din_valid) begin
                    load_s      = 1'b1;
                    load_word_s = din;
                end else begin
                    load_s      = 1'b0;
                end
            end
            SHIFT: begin
                if (cnt_r == CW'(LAST)) begin
                    finish_s = 1'b1;
                    if ((GAP == 0) && hold_full_r) begin
                        load_s      = 1'b1;
                        from_hold_s = 1'b1;
                    end else begin
                        load_s = 1'b0;
                    end
                end else begin
                    finish_s = 1'b0;
                end
            end
            GAP_ST: begin
                if ((gap_cnt_r == GW'(GAP_LAST)) && hold_full_r) begin
                    load_s      = 1'b1;
                    from_hold_s = 1'b1;
                end else begin
                    load_s = 1'b0;
                end
            end
            default: begin
                load_s = 1'b0;
            end
        endcase
    end

    // Transmit FSM, hold buffer and registered serial outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            shift_r     <= '0;
            cnt_r       <= '0;
            gap_cnt_r   <= '0;
            hold_r      <= '0;
            hold_full_r <= 1'b0;
            out_r       <= 1'b0;
            frame_r     <= 1'b0;
            done_r      <= 1'b0;
`ifdef ADC_SERIAL_WRITE_PARITY_EN
            par_r       <= 1'b0;
`endif
        end else begin
            done_r <= finish_s;
            if (to_hold_s) begin
                hold_r      <= din;
                hold_full_r <= 1'b1;
            end else if (from_hold_s) begin
                hold_full_r <= 1'b0;
            end
            if (load_s) begin
                state_r <= SHIFT;
                shift_r <= {load_word_s[WIDTH-2:0], 1'b0};
                out_r   <= load_word_s[WIDTH-1];
                frame_r <= 1'b1;
                cnt_r   <= '0;
`ifdef ADC_SERIAL_WRITE_PARITY_EN
                par_r   <= even_parity(load_word_s);
`endif
            end else begin
                case (state_r)
                    IDLE: begin
                        out_r   <= 1'b0;
                        frame_r <= 1'b0;
                    end
                    SHIFT: begin
                        if (finish_s) begin
                            out_r     <= 1'b0;
                            frame_r   <= 1'b0;
                            gap_cnt_r <= '0;
                            state_r   <= (GAP > 0) ? GAP_ST : IDLE;
                        end else begin
                            cnt_r   <= cnt_r + CW'(1);
                            shift_r <= {shift_r[WIDTH-2:0], 1'b0};
`ifdef ADC_SERIAL_WRITE_PARITY_EN
                            out_r   <= (cnt_r == CW'(WIDTH - 1)) ? par_r : shift_r[WIDTH-1];
`else
                            out_r   <= shift_r[WIDTH-1];
`endif
                        end
                    end
                    GAP_ST: begin
                        out_r   <= 1'b0;
                        frame_r <= 1'b0;
                        if (gap_cnt_r == GW'(GAP_LAST)) begin
                            state_r <= IDLE;
                        end else begin
                            gap_cnt_r <= gap_cnt_r + GW'(1);
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                        out_r   <= 1'b0;
                        frame_r <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_adc_serial_write.sv
// Directed bench for adc_serial_write: one instance with GAP=1, one with GAP=0.
// Expectations follow ADC_SERIAL_WRITE_PARITY_EN when it is defined.
module tb_adc_serial_write;

`ifdef ADC_SERIAL_WRITE_PARITY_EN
    localparam int L = 13;
`else
    localparam int L = 12;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [11:0] din1 = 12'h000;
    logic        valid1 = 1'b0;
    logic        ready1, out1, frame1, done1;
    logic [11:0] din0 = 12'h000;
    logic        valid0 = 1'b0;
    logic        ready0, out0, frame0, done0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    adc_serial_write #(.WIDTH(12), .GAP(1)) dut (
        .clk(clk), .rst(rst), .din(din1), .din_valid(valid1),
        .din_ready(ready1), .out(out1), .frame(frame1), .done(done1)
    );

    adc_serial_write #(.WIDTH(12), .GAP(0)) dut0 (
        .clk(clk), .rst(rst), .din(din0), .din_valid(valid0),
        .din_ready(ready0), .out(out0), .frame(frame0), .done(done0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected j-th frame bit of word w: data MSB first, then the parity bit.
    function automatic logic bit_of(input logic [11:0] w, input int j);
        if (j < 12) return w[11-j];
        return ^w;
    endfunction

    logic q_bits[$];
    int   first_f = -1;
    int   last_f  = -1;
    int   cyc0    = 0;
    int   done_cnt0 = 0;

    task automatic tick0();
        tick();
        if (frame0) begin
            q_bits.push_back(out0);
            if (first_f < 0) first_f = cyc0;
            last_f = cyc0;
        end
        if (done0) done_cnt0++;
        cyc0++;
    endtask

    initial begin
        logic [11:0] w;
        logic [11:0] wa;
        logic [11:0] wb;
        logic [11:0] w4 [3];
        logic [11:0] rebuilt;
        logic        fr_e, out_e, done_e, rdy_e;
        int          waited;
        int          fr_seen;
        int          dn_seen;

        // 1: reset
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        check("rst_out", out1, 1'b0);
        check("rst_frame", frame1, 1'b0);
        check("rst_done", done1, 1'b0);
        check("rst_ready", ready1, 1'b1);
        check("rst_ready0", ready0, 1'b1);

        // 2: single word 12'hAEF, parity of 9 ones is 1
        w = 12'hAEF;
        din1 = w;
        valid1 = 1'b1;
        tick();
        valid1 = 1'b0;
        for (int i = 0; i < L; i++) begin
            out_e = (i < 12) ? w[11-i] : 1'b1;
            check($sformatf("t2_out%0d", i), out1, out_e);
            check($sformatf("t2_frame%0d", i), frame1, 1'b1);
            check($sformatf("t2_done%0d", i), done1, 1'b0);
            tick();
        end
        check("t2_done_pulse", done1, 1'b1);
        check("t2_frame_end", frame1, 1'b0);
        tick();
        check("t2_done_clear", done1, 1'b0);
        repeat (2) tick();

        // 3: GAP=1, second word waits in hold
        wa = 12'h800;
        wb = 12'h001;
        din1 = wa;
        valid1 = 1'b1;
        tick();
        for (int k = 0; k < 2 * L + 4; k++) begin
            fr_e   = (k < L) || (k >= L + 1 && k < 2 * L + 1);
            out_e  = (k < L) ? bit_of(wa, k) : ((k >= L + 1 && k < 2 * L + 1) ? bit_of(wb, k - L - 1) : 1'b0);
            done_e = (k == L) || (k == 2 * L + 1);
            rdy_e  = !(k >= 1 && k <= L);
            check($sformatf("t3_frame%0d", k), frame1, fr_e);
            check($sformatf("t3_out%0d", k), out1, out_e);
            check($sformatf("t3_done%0d", k), done1, done_e);
            check($sformatf("t3_ready%0d", k), ready1, rdy_e);
            if (k == 0) din1 = wb;
            if (k == 1) valid1 = 1'b0;
            tick();
        end
        tick();

        // 4: GAP=0, three back-to-back words
        w4[0] = 12'hFFF;
        w4[1] = 12'h000;
        w4[2] = 12'hA5A;
        for (int i = 0; i < 3; i++) begin
            din0 = w4[i];
            valid0 = 1'b1;
            waited = 0;
            while (!ready0 && waited < 50) begin
                tick0();
                waited++;
            end
            if (waited >= 50) check($sformatf("t4_ready_timeout%0d", i), 32'd0, 32'd1);
            tick0();
            valid0 = 1'b0;
        end
        waited = 0;
        while (done_cnt0 < 3 && waited < 100) begin
            tick0();
            waited++;
        end
        repeat (3) tick0();
        check("t4_done_count", done_cnt0, 3);
        check("t4_frame_bits", q_bits.size(), 3 * L);
        check("t4_contiguous", last_f - first_f + 1, 3 * L);
        for (int i = 0; i < 3; i++) begin
            rebuilt = 12'h000;
            for (int j = 0; j < 12; j++) begin
                if (i * L + j < q_bits.size()) rebuilt[11-j] = q_bits[i * L + j];
            end
            check($sformatf("t4_word%0d", i), rebuilt, w4[i]);
`ifdef ADC_SERIAL_WRITE_PARITY_EN
            if (i * L + 12 < q_bits.size())
                check($sformatf("t4_parity%0d", i), q_bits[i * L + 12], ^w4[i]);
`endif
        end
        check("t4_idle_frame", frame0, 1'b0);

        // 5: reset mid-word with a word held
        din1 = 12'hAEF;
        valid1 = 1'b1;
        tick();
        din1 = 12'h123;
        tick();
        valid1 = 1'b0;
        check("t5_held", ready1, 1'b0);
        repeat (4) tick();
        check("t5_frame_bit6", frame1, 1'b1);
        check("t5_out_bit6", out1, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_out", out1, 1'b0);
        check("t5_frame", frame1, 1'b0);
        check("t5_done", done1, 1'b0);
        check("t5_ready", ready1, 1'b1);
        fr_seen = 0;
        dn_seen = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (frame1) fr_seen++;
            if (done1) dn_seen++;
        end
        check("t5_no_frame", fr_seen, 0);
        check("t5_no_done", dn_seen, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
